// File: rtl/atm_session_controller_if.sv
// ----------------------------------------------------------------------------
// atm_session_controller_if
//   Bundles the user-facing signals of the ATM session controller.
//   master : card reader / keypad side (drives card, PIN, menu and keys)
//   slave  : controller side (drives displays, pulses, lockout and busy)
//   Inputs : card_in, acc_id, pin/pin_valid, opcode/op_valid,
//            amount/amount_valid, dest_acc/dest_valid, confirm, cancel
//   Outputs: balance_out/balance_valid, op_done, op_error/err_code,
//            print_receipt, card_eject, card_retained, locked[N_ACC], busy
// ----------------------------------------------------------------------------
interface atm_session_controller_if #(
   parameter int unsigned N_ACC = 4,
   parameter int unsigned ACC_W = 2,
   parameter int unsigned BAL_W = 32,
   parameter int unsigned PIN_W = 14
);
   logic              card_in;
   logic [ACC_W-1:0]  acc_id;
   logic [PIN_W-1:0]  pin;
   logic              pin_valid;
   logic [2:0]        opcode;
   logic              op_valid;
   logic [BAL_W-1:0]  amount;
   logic              amount_valid;
   logic [ACC_W-1:0]  dest_acc;
   logic              dest_valid;
   logic              confirm;
   logic              cancel;
   logic [BAL_W-1:0]  balance_out;
   logic              balance_valid;
   logic              op_done;
   logic              op_error;
   logic [2:0]        err_code;
   logic              print_receipt;
   logic              card_eject;
   logic              card_retained;
   logic [N_ACC-1:0]  locked;
   logic              busy;

   modport master (
      output card_in, acc_id, pin, pin_valid, opcode, op_valid,
             amount, amount_valid, dest_acc, dest_valid, confirm, cancel,
      input  balance_out, balance_valid, op_done, op_error, err_code,
             print_receipt, card_eject, card_retained, locked, busy
   );

   modport slave (
      input  card_in, acc_id, pin, pin_valid, opcode, op_valid,
             amount, amount_valid, dest_acc, dest_valid, confirm, cancel,
      output balance_out, balance_valid, op_done, op_error, err_code,
             print_receipt, card_eject, card_retained, locked, busy
   );
endinterface

// File: rtl/atm_session_controller.sv
// ----------------------------------------------------------------------------
// atm_session_controller
//   Session FSM for an ATM with an internal account table (balance, PIN,
//   lockout flag per account). Handles card insertion, PIN check with
//   lockout, balance query, withdraw, deposit, transfer, PIN change,
//   receipts and an inactivity timeout.
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : atm_session_controller_if.slave (all user inputs / outputs)
//   All pulse outputs are registered and last one cycle; err_code holds the
//   code of the most recent op_error.
// ----------------------------------------------------------------------------
module atm_session_controller #(
   parameter int unsigned      N_ACC     = 4,
   parameter int unsigned      ACC_W     = 2,
   parameter int unsigned      BAL_W     = 32,
   parameter int unsigned      PIN_W     = 14,
   parameter int unsigned      MAX_TRIES = 3,
   parameter int unsigned      TIMEOUT   = 1000,
   parameter logic [BAL_W-1:0] INIT_BAL  = 100000,
   parameter logic [PIN_W-1:0] INIT_PIN  = 8030
) (
   input logic                     clk,
   input logic                     reset,
   atm_session_controller_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PIN, S_MENU, S_GET_DEST, S_GET_AMT,
      S_CONFIRM, S_EXEC, S_RECEIPT, S_NEWPIN, S_EJECT
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE, ERR_BAD_PIN, ERR_LOCKED, ERR_INSUFF,
      ERR_OVERFLOW, ERR_BAD_DEST, ERR_BAD_OP, ERR_TIMEOUT
   } err_e;

   typedef enum logic [2:0] {
      OP_EJECT, OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT,
      OP_TRANSFER, OP_NEWPIN, OP_RSVD6, OP_RSVD7
   } op_e;

   state_e            state_q, state_d;
   op_e               opc_q, opc_d;
   err_e              err_code_q, err_code_d, err_c;
   logic [ACC_W-1:0]  acc_q, acc_d, dest_q, dest_d;
   logic [BAL_W-1:0]  amt_q, amt_d, bal_out_q, bal_out_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [CNT_W-1:0]  idle_q, idle_d;
   logic [BAL_W-1:0]  bal_q [N_ACC];
   logic [BAL_W-1:0]  bal_d [N_ACC];
   logic [PIN_W-1:0]  pin_q [N_ACC];
   logic [PIN_W-1:0]  pin_d [N_ACC];
   logic [N_ACC-1:0]  locked_q, locked_d;
   logic              bal_valid_q, bal_valid_d, op_done_q, op_done_d;
   logic              op_error_q, op_error_d, receipt_q, receipt_d;
   logic              eject_q, eject_d, retained_q, retained_d;
   logic              strobe, in_session;
   logic [BAL_W:0]    src_plus, dst_plus;

   assign strobe     = bus.pin_valid | bus.op_valid | bus.dest_valid |
                       bus.amount_valid | bus.confirm | bus.cancel;
   assign in_session = (state_q != S_IDLE) && (state_q != S_EJECT);
   // One extra bit exposes overflow past 2**BAL_W-1.
   assign src_plus   = {1'b0, bal_q[acc_q]}  + {1'b0, bus.amount};
   assign dst_plus   = {1'b0, bal_q[dest_q]} + {1'b0, bus.amount};

   always_comb begin
      state_d     = state_q;
      opc_d       = opc_q;
      acc_d       = acc_q;
      dest_d      = dest_q;
      amt_d       = amt_q;
      tries_d     = tries_q;
      idle_d      = '0;
      bal_d       = bal_q;
      pin_d       = pin_q;
      locked_d    = locked_q;
      bal_out_d   = bal_out_q;
      err_code_d  = err_code_q;
      err_c       = ERR_NONE;
      bal_valid_d = 1'b0;
      op_done_d   = 1'b0;
      receipt_d   = 1'b0;
      retained_d  = 1'b0;

      if (in_session) idle_d = strobe ? '0 : idle_q + CNT_W'(1);

      // Card pull beats timeout, which beats any state-specific action.
      if (in_session && !bus.card_in) begin
         state_d = S_IDLE;
      end else if (in_session && !strobe && (int'(idle_q) + 1) >= int'(TIMEOUT)) begin
         err_c   = ERR_TIMEOUT;
         state_d = S_EJECT;
      end else begin
         case (state_q)
            S_IDLE: if (bus.card_in) begin
               acc_d = bus.acc_id;
               if (int'(bus.acc_id) >= int'(N_ACC)) begin
                  err_c = ERR_BAD_DEST; state_d = S_EJECT;
               end else if (locked_q[bus.acc_id]) begin
                  err_c = ERR_LOCKED;   state_d = S_EJECT;
               end else begin
                  tries_d = '0;         state_d = S_PIN;
               end
            end
            S_PIN: if (bus.cancel) begin
               state_d = S_EJECT;
            end else if (bus.pin_valid) begin
               if (bus.pin == pin_q[acc_q]) begin
                  state_d = S_MENU;
               end else begin
                  err_c   = ERR_BAD_PIN;
                  tries_d = tries_q + TRY_W'(1);
                  if ((int'(tries_q) + 1) >= int'(MAX_TRIES)) begin
                     locked_d[acc_q] = 1'b1;
                     retained_d      = 1'b1;
                     state_d         = S_IDLE;
                  end
               end
            end
            S_MENU: if (bus.cancel) begin
               state_d = S_EJECT;
            end else if (bus.op_valid) begin
               opc_d = op_e'(bus.opcode);
               case (op_e'(bus.opcode))
                  OP_EJECT:    state_d = S_EJECT;
                  OP_BALANCE: begin
                     bal_out_d   = bal_q[acc_q];
                     bal_valid_d = 1'b1;
                     state_d     = S_RECEIPT;
                  end
                  OP_WITHDRAW,
                  OP_DEPOSIT:  state_d = S_GET_AMT;
                  OP_TRANSFER: state_d = S_GET_DEST;
                  OP_NEWPIN:   state_d = S_NEWPIN;
                  default:     err_c   = ERR_BAD_OP;
               endcase
            end
            S_GET_DEST: if (bus.cancel) begin
               state_d = S_MENU;
            end else if (bus.dest_valid) begin
               if (bus.dest_acc == acc_q || int'(bus.dest_acc) >= int'(N_ACC)) begin
                  err_c = ERR_BAD_DEST; state_d = S_MENU;
               end else begin
                  dest_d = bus.dest_acc; state_d = S_GET_AMT;
               end
            end
            S_GET_AMT: if (bus.cancel) begin
               state_d = S_MENU;
            end else if (bus.amount_valid) begin
               if (bus.amount == '0) begin
                  err_c = ERR_BAD_OP;
               end else if (opc_q != OP_DEPOSIT && bus.amount > bal_q[acc_q]) begin
                  err_c = ERR_INSUFF;   state_d = S_MENU;
               end else if ((opc_q == OP_DEPOSIT && src_plus[BAL_W]) ||
                            (opc_q == OP_TRANSFER && dst_plus[BAL_W])) begin
                  err_c = ERR_OVERFLOW; state_d = S_MENU;
               end else begin
                  amt_d = bus.amount;   state_d = S_CONFIRM;
               end
            end
            S_CONFIRM: if (bus.cancel) begin
               state_d = S_MENU;
            end else if (bus.confirm) begin
               state_d = S_EXEC;
            end
            S_EXEC: begin
               case (opc_q)
                  OP_WITHDRAW: bal_d[acc_q] = bal_q[acc_q] - amt_q;
                  OP_DEPOSIT:  bal_d[acc_q] = bal_q[acc_q] + amt_q;
                  OP_TRANSFER: begin
                     bal_d[acc_q]  = bal_q[acc_q]  - amt_q;
                     bal_d[dest_q] = bal_q[dest_q] + amt_q;
                  end
                  default: ;
               endcase
               op_done_d = 1'b1;
               state_d   = S_RECEIPT;
            end
            S_RECEIPT: if (bus.cancel) begin
               state_d = S_MENU;
            end else if (bus.confirm) begin
               receipt_d = 1'b1; state_d = S_MENU;
            end
            S_NEWPIN: if (bus.cancel) begin
               state_d = S_MENU;
            end else if (bus.pin_valid) begin
               pin_d[acc_q] = bus.pin;
               op_done_d    = 1'b1;
               state_d      = S_MENU;
            end
            S_EJECT: if (!bus.card_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      op_error_d = (err_c != ERR_NONE);
      if (err_c != ERR_NONE) err_code_d = err_c;
      eject_d = (state_d == S_EJECT) && (state_q != S_EJECT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         opc_q       <= OP_EJECT;
         err_code_q  <= ERR_NONE;
         acc_q       <= '0;
         dest_q      <= '0;
         amt_q       <= '0;
         tries_q     <= '0;
         idle_q      <= '0;
         locked_q    <= '0;
         bal_out_q   <= '0;
         bal_valid_q <= 1'b0;
         op_done_q   <= 1'b0;
         op_error_q  <= 1'b0;
         receipt_q   <= 1'b0;
         eject_q     <= 1'b0;
         retained_q  <= 1'b0;
         for (int unsigned i = 0; i < N_ACC; i++) begin
            bal_q[i] <= INIT_BAL;
            pin_q[i] <= INIT_PIN;
         end
      end else begin
         state_q     <= state_d;
         opc_q       <= opc_d;
         err_code_q  <= err_code_d;
         acc_q       <= acc_d;
         dest_q      <= dest_d;
         amt_q       <= amt_d;
         tries_q     <= tries_d;
         idle_q      <= idle_d;
         locked_q    <= locked_d;
         bal_out_q   <= bal_out_d;
         bal_valid_q <= bal_valid_d;
         op_done_q   <= op_done_d;
         op_error_q  <= op_error_d;
         receipt_q   <= receipt_d;
         eject_q     <= eject_d;
         retained_q  <= retained_d;
         bal_q       <= bal_d;
         pin_q       <= pin_d;
      end
   end

   assign bus.balance_out   = bal_out_q;
   assign bus.balance_valid = bal_valid_q;
   assign bus.op_done       = op_done_q;
   assign bus.op_error      = op_error_q;
   assign bus.err_code      = err_code_q;
   assign bus.print_receipt = receipt_q;
   assign bus.card_eject    = eject_q;
   assign bus.card_retained = retained_q;
   assign bus.locked        = locked_q;
   assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_atm_session_controller.sv
// ----------------------------------------------------------------------------
// tb_atm_session_controller
//   Directed session scenarios for atm_session_controller with hand-computed
//   expectations: withdraw + receipt, PIN lockout, transfers, overflow and
//   exact-limit boundaries, confirm/cancel collision, inactivity timeout,
//   card removal and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_atm_session_controller;
   localparam int unsigned TIMEOUT = 1000;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   atm_session_controller_if #(.N_ACC(4), .ACC_W(2), .BAL_W(32), .PIN_W(14)) bus ();

   atm_session_controller #(
      .N_ACC(4), .ACC_W(2), .BAL_W(32), .PIN_W(14), .MAX_TRIES(3),
      .TIMEOUT(TIMEOUT), .INIT_BAL(32'd100000), .INIT_PIN(14'd8030)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [1:0] a);
      bus.acc_id = a; bus.card_in = 1'b1; tick();
   endtask
   task automatic remove_card();
      bus.card_in = 1'b0; tick(); tick();
   endtask
   task automatic key_pin(input logic [13:0] p);
      bus.pin = p; bus.pin_valid = 1'b1; tick(); bus.pin_valid = 1'b0;
   endtask
   task automatic key_op(input logic [2:0] o);
      bus.opcode = o; bus.op_valid = 1'b1; tick(); bus.op_valid = 1'b0;
   endtask
   task automatic key_amt(input logic [31:0] a);
      bus.amount = a; bus.amount_valid = 1'b1; tick(); bus.amount_valid = 1'b0;
   endtask
   task automatic key_dest(input logic [1:0] d);
      bus.dest_acc = d; bus.dest_valid = 1'b1; tick(); bus.dest_valid = 1'b0;
   endtask
   task automatic key_confirm();
      bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
   endtask
   task automatic key_cancel();
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
   endtask
   // Balance query from MENU, then back to MENU without printing.
   task automatic query(input string tag, input logic [31:0] exp);
      key_op(3'd1);
      chk({tag, "_valid"}, bus.balance_valid, 1);
      chk(tag, bus.balance_out, exp);
      key_cancel();
      chk({tag, "_noprint"}, bus.print_receipt, 0);
   endtask

   initial begin
      int ej_at, n_ej;
      logic [2:0] ej_code;
      reset = 1'b1;
      bus.card_in = 0; bus.acc_id = 0; bus.pin = 0; bus.pin_valid = 0;
      bus.opcode = 0; bus.op_valid = 0; bus.amount = 0; bus.amount_valid = 0;
      bus.dest_acc = 0; bus.dest_valid = 0; bus.confirm = 0; bus.cancel = 0;
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_err_code", bus.err_code, 0);
      chk("rst_bal_out", bus.balance_out, 0);
      #8 reset = 1'b0;
      tick();

      // Withdraw 30000 from acc 1, confirm, print receipt, check balance.
      insert(2'd1);
      chk("p1_busy", bus.busy, 1);
      key_pin(14'd8030);
      chk("p1_pin_ok", bus.op_error, 0);
      key_op(3'd2);
      key_amt(32'd30000);
      key_confirm();
      chk("p1_exec_not_yet", bus.op_done, 0);
      tick();
      chk("p1_op_done", bus.op_done, 1);
      key_confirm();
      chk("p1_receipt", bus.print_receipt, 1);
      query("p1_bal", 32'd70000);
      key_cancel();
      chk("p1_eject", bus.card_eject, 1);
      tick();
      chk("p1_eject_once", bus.card_eject, 0);
      remove_card();
      chk("p1_idle", bus.busy, 0);

      // Three wrong PINs on acc 2 lock it; reinsertion is refused.
      insert(2'd2);
      for (int i = 0; i < 3; i++) begin
         key_pin(14'd1234);
         chk("p2_bad_pin_err", bus.op_error, 1);
         chk("p2_bad_pin_code", bus.err_code, 1);
      end
      chk("p2_retained", bus.card_retained, 1);
      chk("p2_no_eject", bus.card_eject, 0);
      chk("p2_locked", bus.locked, 4'b0100);
      chk("p2_idle", bus.busy, 0);
      bus.card_in = 1'b0;
      tick();
      insert(2'd2);
      chk("p2_locked_err", bus.op_error, 1);
      chk("p2_locked_code", bus.err_code, 2);
      chk("p2_locked_eject", bus.card_eject, 1);
      remove_card();

      // Transfer the whole of acc 0 to acc 3, then try one more unit.
      insert(2'd0);
      key_pin(14'd8030);
      key_op(3'd4);
      key_dest(2'd3);
      key_amt(32'd100000);
      chk("p3_amt_ok", bus.op_error, 0);
      key_confirm();
      tick();
      chk("p3_op_done", bus.op_done, 1);
      key_cancel();
      query("p3_acc0", 32'd0);
      key_op(3'd4);
      key_dest(2'd3);
      key_amt(32'd1);
      chk("p3_insuff_err", bus.op_error, 1);
      chk("p3_insuff_code", bus.err_code, 3);
      query("p3_acc0_again", 32'd0);
      key_op(3'd4);
      key_dest(2'd0);
      chk("p3_self_dest_code", bus.err_code, 5);
      key_op(3'd6);
      chk("p3_bad_op_code", bus.err_code, 6);
      key_cancel();
      remove_card();
      insert(2'd3);
      key_pin(14'd8030);
      query("p3_acc3", 32'd200000);
      key_cancel();
      remove_card();

      // Asynchronous reset while a withdraw waits in CONFIRM.
      insert(2'd1);
      key_pin(14'd8030);
      key_op(3'd2);
      key_amt(32'd5000);
      #3 reset = 1'b1;
      #1;
      chk("ar_busy", bus.busy, 0);
      chk("ar_err_code", bus.err_code, 0);
      chk("ar_locked", bus.locked, 0);
      chk("ar_bal_out", bus.balance_out, 0);
      chk("ar_op_done", bus.op_done, 0);
      bus.card_in = 1'b0;
      #4 reset = 1'b0;
      tick();

      // Deposit overflow boundary on acc 1 (back to 100000), then withdraw all.
      insert(2'd1);
      key_pin(14'd8030);
      query("p4_init", 32'd100000);
      key_op(3'd3);
      key_amt(32'd4294867296);
      chk("p4_ovf_code", bus.err_code, 4);
      chk("p4_ovf_err", bus.op_error, 1);
      key_op(3'd3);
      key_amt(32'd4294867295);
      chk("p4_max_ok", bus.op_error, 0);
      key_confirm();
      tick();
      chk("p4_dep_done", bus.op_done, 1);
      key_cancel();
      query("p4_bal_max", 32'hFFFF_FFFF);
      key_op(3'd2);
      key_amt(32'd0);
      chk("p4_zero_code", bus.err_code, 6);
      key_amt(32'hFFFF_FFFF);
      chk("p4_all_ok", bus.op_error, 0);
      key_confirm();
      tick();
      chk("p4_wd_done", bus.op_done, 1);
      key_cancel();
      query("p4_bal_zero", 32'd0);

      // confirm and cancel together in CONFIRM: cancel wins.
      key_op(3'd3);
      key_amt(32'd10);
      bus.confirm = 1'b1; bus.cancel = 1'b1;
      tick();
      bus.confirm = 1'b0; bus.cancel = 1'b0;
      chk("p5_cc_no_done", bus.op_done, 0);
      tick();
      chk("p5_cc_no_exec", bus.op_done, 0);
      query("p5_cc_bal", 32'd0);

      // Inactivity timeout in GET_AMT.
      key_op(3'd2);
      ej_at = 0; n_ej = 0; ej_code = 3'd0;
      for (int i = 1; i <= int'(TIMEOUT) + 20; i++) begin
         tick();
         if (bus.card_eject) begin
            n_ej++;
            if (ej_at == 0) begin
               ej_at   = i;
               ej_code = bus.err_code;
            end
         end
      end
      chk("p5_to_cycle", ej_at, TIMEOUT);
      chk("p5_to_code", ej_code, 7);
      chk("p5_to_eject_count", n_ej, 1);
      remove_card();
      chk("p5_idle", bus.busy, 0);

      // Card pulled in CONFIRM: no transaction.
      insert(2'd0);
      key_pin(14'd8030);
      key_op(3'd2);
      key_amt(32'd50);
      bus.card_in = 1'b0;
      tick();
      chk("p6_pull_idle", bus.busy, 0);
      chk("p6_pull_no_eject", bus.card_eject, 0);
      tick();
      chk("p6_pull_no_done", bus.op_done, 0);
      insert(2'd0);
      key_pin(14'd8030);
      query("p6_acc0", 32'd100000);
      key_cancel();
      remove_card();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/atm_session_controller.md
ATM_SESSION_CONTROLLER -- requirements
Module: atm_session_controller

Interface
REQ-001 N_ACC, 4, number of accounts held in the internal account table.
REQ-002 ACC_W, 2, account index width; SHALL satisfy 2**ACC_W >= N_ACC.
REQ-003 BAL_W, 32, balance and amount width, unsigned.
REQ-004 PIN_W, 14, PIN width.
REQ-005 MAX_TRIES, 3, wrong PIN entries per session before lockout.
REQ-006 TIMEOUT, 1000, idle cycles in a session before forced eject.
REQ-007 INIT_BAL, 100000, reset balance of every account; INIT_PIN, 8030, reset PIN of every account.
REQ-008 clk in 1 clock; reset in 1 asynchronous, active-high.
REQ-009 card_in in 1 card present (level); acc_id in ACC_W account of inserted card, sampled on session start.
REQ-010 pin in PIN_W, pin_valid in 1 PIN entry strobe; opcode in 3, op_valid in 1 menu selection strobe.
REQ-011 amount in BAL_W, amount_valid in 1 amount strobe; dest_acc in ACC_W, dest_valid in 1 transfer destination strobe.
REQ-012 confirm in 1, cancel in 1 user keys (single-cycle strobes).
REQ-013 balance_out out BAL_W, balance_valid out 1 balance display, one-cycle pulse.
REQ-014 op_done out 1 pulse on completed transaction; op_error out 1 pulse with err_code out 3 (held until next op_error).
REQ-015 print_receipt out 1, card_eject out 1, card_retained out 1 pulses; locked out N_ACC per-account lockout flags; busy out 1 high outside IDLE.

Function
REQ-016 States: IDLE, PIN, MENU, GET_DEST, GET_AMT, CONFIRM, EXEC, RECEIPT, NEWPIN, EJECT; one transition max per cycle.
REQ-017 err_code: 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 OVERFLOW, 5 BAD_DEST, 6 BAD_OP, 7 TIMEOUT.
REQ-018 IDLE: card_in=1 latches acc_id; acc_id>=N_ACC -> error BAD_DEST, EJECT; locked[acc]=1 -> error LOCKED, EJECT; else PIN with tries=0.
REQ-019 PIN: pin_valid and match -> MENU; mismatch -> error BAD_PIN, tries+1; at tries==MAX_TRIES set locked[acc], pulse card_retained, go IDLE (no card_eject).
REQ-020 MENU on op_valid: 0 -> EJECT; 1 -> balance_out=current balance with balance_valid pulse, then RECEIPT; 2 withdraw, 3 deposit -> GET_AMT; 4 transfer -> GET_DEST; 5 -> NEWPIN; 6/7 -> error BAD_OP, stay MENU.
REQ-021 GET_DEST on dest_valid: dest_acc==acc or >=N_ACC -> error BAD_DEST, MENU; else latch, GET_AMT; locked destinations are valid.
REQ-022 GET_AMT on amount_valid: amount 0 -> error BAD_OP, stay; withdraw/transfer amount>source balance -> INSUFFICIENT, MENU; deposit/transfer target sum exceeding 2**BAL_W-1 -> OVERFLOW, MENU; else latch, CONFIRM.
REQ-023 amount equal to balance is legal (balance becomes 0); sum exactly 2**BAL_W-1 is legal.
REQ-024 CONFIRM: confirm -> EXEC; cancel -> MENU, no table change; confirm and cancel same cycle -> cancel wins.
REQ-025 EXEC: single cycle, updates table (transfer debits source and credits destination in the same cycle), pulses op_done, then RECEIPT.
REQ-026 RECEIPT: confirm -> print_receipt pulse, MENU; cancel -> MENU, no print.
REQ-027 NEWPIN: pin_valid writes pin to account, op_done pulse, MENU; cancel -> MENU unchanged.
REQ-028 cancel in PIN or MENU -> EJECT; cancel in GET_DEST/GET_AMT -> MENU.
REQ-029 Inactivity counter clears on any strobe (pin_valid, op_valid, dest_valid, amount_valid, confirm, cancel) and on entering PIN; counts in PIN..NEWPIN; reaching TIMEOUT -> error TIMEOUT, EJECT, no table change.
REQ-030 card_in=0 in any non-IDLE, non-EJECT state -> IDLE immediately, no table change, no card_eject.
REQ-031 EJECT: card_eject pulses on entry cycle only; remain until card_in=0, then IDLE.
REQ-032 Strobes arriving in states that do not consume them are ignored.

Reset
REQ-033 On reset: state IDLE; all balances INIT_BAL, all PINs INIT_PIN, locked=0, tries=0, counters 0; all outputs 0, err_code 0.
REQ-034 Lockout persists across sessions; only reset clears it.

Verification
REQ-035 Acc 1, PIN 8030, withdraw 30000, confirm, confirm -> op_done, print_receipt, balance query shows 70000.
REQ-036 Acc 2, three wrong PINs (1234) -> three BAD_PIN errors, card_retained, locked[2]=1; reinsert acc 2 -> LOCKED, card_eject.
REQ-037 Acc 0 transfer 100000 to acc 3 -> acc0=0, acc3=200000; then transfer 1 -> INSUFFICIENT, balances unchanged.
REQ-038 Deposit 2**32-100000 to acc 1 -> OVERFLOW; deposit 2**32-100001 -> succeeds, balance 2**32-1.
REQ-039 MENU, withdraw, no input for TIMEOUT cycles -> TIMEOUT, card_eject once; confirm+cancel same cycle in CONFIRM -> MENU, balance unchanged.
REQ-040 reset asserted during EXEC-bound CONFIRM -> IDLE, balances INIT_BAL, outputs 0 without waiting for clk.
